// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared state encoding, requester indices and DM register addresses for the DM arbiter.
package dm_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, ERR, GAP} state_t;
  localparam logic REQ_JTAG = 1'b0;
  localparam logic REQ_UART = 1'b1;
  localparam logic [31:0] DM_DATA0     = 32'h04;
  localparam logic [31:0] DM_DATA1     = 32'h05;
  localparam logic [31:0] DM_DMCONTROL = 32'h10;
  localparam logic [31:0] DM_COMMAND   = 32'h17;
endpackage

// File: rtl/dm_arb_rr_pick.sv
// dm_arb_rr_pick: combinational two-way round-robin pick from a request vector and the last grant.
module dm_arb_rr_pick
  import dm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       pick,
  output logic       vld
);
  assign vld  = |req;
  assign pick = (&req) ? ~last_grant : req[REQ_UART];
endmodule

// File: rtl/wishbone_dm_arbiter.sv
// wishbone_dm_arbiter: round-robin Wishbone arbiter (JTAG DTM / UART bridge) in front of the DM slave.
// Optional DM_ARB_STATS_EN adds saturating grant and timeout counters.
module wishbone_dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GAP_CYCLES     = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_ack_i,
  output logic [1:0]        grant_o,
  output logic              busy_o
`ifdef DM_ARB_STATS_EN
  ,
  output logic [15:0]       m0_grant_cnt_o,
  output logic [15:0]       m1_grant_cnt_o,
  output logic [15:0]       timeout_cnt_o
`endif
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  state_t state, state_n;
  logic owner, owner_n, last_grant, last_grant_n, pick, pick_vld, own_req, in_busy;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [1:0] req;
  assign req     = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign own_req = req[owner];
  assign in_busy = state == BUSY;
  dm_arb_rr_pick u_pick (.req(req), .last_grant(last_grant), .pick(pick), .vld(pick_vld));
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state      <= IDLE;
      owner      <= REQ_JTAG;
      last_grant <= REQ_UART;
      tcnt       <= '0;
      gcnt       <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_grant <= last_grant_n;
      tcnt       <= tcnt_n;
      gcnt       <= gcnt_n;
    end
  // Owner drop outranks timeout, and ack outranks timeout.
  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_grant_n = last_grant;
    tcnt_n       = tcnt;
    gcnt_n       = gcnt;
    case (state)
      IDLE: if (pick_vld) begin
        state_n      = BUSY;
        owner_n      = pick;
        last_grant_n = pick;
        tcnt_n       = '0;
      end
      BUSY:
        if (!own_req) begin
          state_n = GAP;
          gcnt_n  = '0;
        end else if (s_ack_i) tcnt_n = '0;
        else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) state_n = ERR;
        else tcnt_n = tcnt + 1'b1;
      ERR: if (!(owner ? m1_cyc_i : m0_cyc_i)) begin
        state_n = GAP;
        gcnt_n  = '0;
      end
      GAP: if (gcnt == GW'(GAP_CYCLES - 1)) state_n = IDLE; else gcnt_n = gcnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  assign s_cyc_o   = in_busy & (owner ? m1_cyc_i : m0_cyc_i);
  assign s_stb_o   = in_busy & (owner ? m1_stb_i : m0_stb_i);
  assign s_we_o    = in_busy & (owner ? m1_we_i : m0_we_i);
  assign s_addr_o  = in_busy ? (owner ? m1_addr_i : m0_addr_i) : '0;
  assign s_data_o  = in_busy ? (owner ? m1_data_i : m0_data_i) : '0;
  assign m0_ack_o  = in_busy & !owner & s_ack_i;
  assign m1_ack_o  = in_busy & owner & s_ack_i;
  assign m0_data_o = (in_busy & !owner) ? s_data_i : '0;
  assign m1_data_o = (in_busy & owner) ? s_data_i : '0;
  assign m0_err_o  = (state == ERR) & !owner;
  assign m1_err_o  = (state == ERR) & owner;
  assign grant_o   = (in_busy | state == ERR) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy_o    = state != IDLE;
`ifdef DM_ARB_STATS_EN
  logic grant_edge, to_edge;
  assign grant_edge = state == IDLE && pick_vld;
  assign to_edge    = in_busy && state_n == ERR;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      m0_grant_cnt_o <= '0;
      m1_grant_cnt_o <= '0;
      timeout_cnt_o  <= '0;
    end else begin
      if (grant_edge && !pick && ~&m0_grant_cnt_o) m0_grant_cnt_o <= m0_grant_cnt_o + 1'b1;
      if (grant_edge && pick && ~&m1_grant_cnt_o) m1_grant_cnt_o <= m1_grant_cnt_o + 1'b1;
      if (to_edge && ~&timeout_cnt_o) timeout_cnt_o <= timeout_cnt_o + 1'b1;
    end
`endif
endmodule

// File: tb/tb_wishbone_dm_arbiter.sv
// tb_wishbone_dm_arbiter: table vectors, corner-case sequences and randomized traffic against a transaction-level model.
module tb_wishbone_dm_arbiter;
  import dm_arb_pkg::*;
  localparam int AW = 32, DW = 64, TO = 64, GAPC = 2, N = 20;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0, s_addr;
  logic [DW-1:0] m0_wdat = '0, m1_wdat = '0, m0_rdat, m1_rdat, s_wdat, s_rdat = '0;
  logic m0_ack, m1_ack, m0_err, m1_err, s_cyc, s_stb, s_we, s_ack = 0, busy;
  logic [1:0] grant;
`ifdef DM_ARB_STATS_EN
  logic [15:0] m0_gc, m1_gc, to_c;
`endif
  int errors = 0, checks = 0;
  wishbone_dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAPC)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_wdat),
    .m0_data_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_wdat),
    .m1_data_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_addr_o(s_addr), .s_data_o(s_wdat),
    .s_data_i(s_rdat), .s_ack_i(s_ack), .grant_o(grant), .busy_o(busy)
`ifdef DM_ARB_STATS_EN
    , .m0_grant_cnt_o(m0_gc), .m1_grant_cnt_o(m1_gc), .timeout_cnt_o(to_c)
`endif
  );

  // DM slave stand-in: registered ack after a programmable or random number of wait states.
  logic [DW-1:0] mem [32];
  logic [DW-1:0] ref_mem [32];
  bit s_en = 1, s_rand = 0, mon = 0;
  int s_wait = 0, rw = 0, wcnt = 0, lim;
  assign lim = s_rand ? rw : s_wait;
  always @(posedge clk) begin
    if (rst) begin
      s_ack <= 0;
      wcnt <= 0;
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (s_cyc && s_stb && !s_ack && s_en && wcnt >= lim) begin
      s_ack <= 1;
      wcnt <= 0;
      rw <= $urandom_range(3, 0);
      if (s_we) mem[s_addr[4:0]] <= s_wdat; else s_rdat <= mem[s_addr[4:0]];
    end else begin
      s_ack <= 0;
      wcnt <= (s_cyc && s_stb && !s_ack) ? wcnt + 1 : 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Only the owner sees acks, and the slave sees the owner's address.
  always begin
    @(posedge clk);
    #2;
    if (mon && s_cyc) chk("slave addr follows owner", s_addr, grant[1] ? m1_addr : m0_addr);
    if (mon && (m0_ack || m1_ack)) chk("ack only to owner", {m1_ack, m0_ack}, grant);
  end

  task automatic set_m(input int m, input bit r, input bit we, input logic [31:0] a, input logic [63:0] d);
    if (m == 0) begin
      m0_cyc = r; m0_stb = r; m0_we = we; m0_addr = a; m0_wdat = d;
    end else begin
      m1_cyc = r; m1_stb = r; m1_we = we; m1_addr = a; m1_wdat = d;
    end
  endtask

  function automatic logic ackm(input int m);
    return m != 0 ? m1_ack : m0_ack;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    set_m(0, 0, 0, '0, '0);
    set_m(1, 0, 0, '0, '0);
    s_en = 1; s_wait = 0; s_rand = 0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_grant(output logic [1:0] g);
    int n = 0;
    do begin @(negedge clk); n++; end while (grant == 2'b00 && n < 50);
    g = grant;
  endtask

  task automatic wait_ack(input int m);
    int n = 0;
    while (!ackm(m) && n < 200) begin @(negedge clk); n++; end
    chk(m != 0 ? "m1 ack" : "m0 ack", ackm(m), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    chk("return to idle", busy, 0);
  endtask

  task automatic xfer(input int m, input bit we, input logic [31:0] a, input logic [63:0] d, output logic [63:0] rd);
    @(negedge clk);
    set_m(m, 1, we, a, d);
    wait_ack(m);
    rd = m != 0 ? m1_rdat : m0_rdat;
    set_m(m, 0, 0, '0, '0);
    wait_idle();
  endtask

  task automatic run_master(input int m);
    logic [31:0] dm_addrs [4];
    logic [31:0] a;
    logic [63:0] d;
    bit we;
    int n;
    dm_addrs = '{DM_DATA0, DM_DATA1, DM_DMCONTROL, DM_COMMAND};
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      we = 1'($urandom_range(1, 0));
      a = dm_addrs[$urandom_range(3, 0)];
      d = {$urandom, $urandom};
      set_m(m, 1, we, a, d);
      n = 0;
      while (!ackm(m) && n < 500) begin @(negedge clk); n++; end
      chk("rand ack", ackm(m), 1);
      if (we) ref_mem[a[4:0]] = d;
      else chk("rand read data", m != 0 ? m1_rdat : m0_rdat, ref_mem[a[4:0]]);
      set_m(m, 0, 0, '0, '0);
    end
  endtask

  // Both masters always have work queued, so ownership must strictly alternate starting with m0.
  task automatic grant_order();
    logic [1:0] prevg = 2'b00;
    int n;
    for (int g = 0; g < 2 * N; g++) begin
      n = 0;
      while (!(grant != 2'b00 && prevg == 2'b00) && n < 300) begin
        prevg = grant;
        @(negedge clk);
        n++;
      end
      chk("rand rr order", grant, g % 2 != 0 ? 2'b10 : 2'b01);
      prevg = grant;
    end
  endtask

  typedef struct {bit r0; bit r1; logic [1:0] g;} vec_t;
  vec_t vt [8];
  logic [1:0] g;
  logic [63:0] rd;
  int n;

  initial begin
    vt[0] = '{1, 1, 2'b01}; vt[1] = '{1, 1, 2'b10}; vt[2] = '{1, 0, 2'b01}; vt[3] = '{1, 0, 2'b01};
    vt[4] = '{0, 1, 2'b10}; vt[5] = '{0, 1, 2'b10}; vt[6] = '{1, 1, 2'b01}; vt[7] = '{1, 1, 2'b10};
    do_reset();
    chk("reset grant", grant, 0);
    chk("reset busy", busy, 0);
    chk("reset slave cyc", {s_cyc, s_stb, s_we}, 0);
    chk("reset masters", {m0_ack, m1_ack, m0_err, m1_err}, 0);
    // Arbitration table, each vector continuing from the previous last_grant.
    foreach (vt[i]) begin
      @(negedge clk);
      set_m(0, vt[i].r0, 0, DM_DATA0, '0);
      set_m(1, vt[i].r1, 0, DM_DATA0, '0);
      wait_grant(g);
      chk("table grant", g, vt[i].g);
      wait_ack(g[1] ? 1 : 0);
      set_m(0, 0, 0, '0, '0);
      set_m(1, 0, 0, '0, '0);
      wait_idle();
    end
    // Single m0 write then read of data0, with one-cycle grant latency.
    do_reset();
    xfer(0, 1, DM_DATA0, 64'h1122334455667788, rd);
    @(negedge clk);
    set_m(0, 1, 0, DM_DATA0, '0);
    chk("no slave cyc before grant", s_cyc, 0);
    @(negedge clk);
    chk("slave cyc one cycle later", s_cyc, 1);
    chk("m0 granted", grant, 2'b01);
    wait_ack(0);
    chk("m0 read data0", m0_rdat, 64'h1122334455667788);
    chk("m1 ack quiet", m1_ack, 0);
    set_m(0, 0, 0, '0, '0);
    wait_idle();
    // Simultaneous request after reset, then the gap before m1.
    do_reset();
    @(negedge clk);
    set_m(0, 1, 0, DM_DATA1, '0);
    set_m(1, 1, 0, DM_DATA1, '0);
    wait_grant(g);
    chk("tie goes to m0", g, 2'b01);
    wait_ack(0);
    set_m(0, 0, 0, '0, '0);
    n = 0;
    do begin @(negedge clk); if (busy && grant == 2'b00) n++; end while (grant == 2'b00 && n < 40);
    chk("gap cycles", n, GAPC);
    chk("m1 after gap", grant, 2'b10);
    wait_ack(1);
    set_m(1, 0, 0, '0, '0);
    wait_idle();
    // Back-to-back m0 writes with m1 held pending.
    @(negedge clk);
    set_m(0, 1, 1, DM_COMMAND, 64'hA5);
    set_m(1, 1, 0, DM_COMMAND, '0);
    for (int k = 0; k < 3; k++) begin
      wait_grant(g);
      chk("alternating grants", g, k == 1 ? 2'b10 : 2'b01);
      wait_ack(g[1] ? 1 : 0);
      set_m(g[1] ? 1 : 0, 0, 0, '0, '0);
      if (k == 0) begin @(negedge clk); set_m(0, 1, 1, DM_COMMAND, 64'h5A); end
    end
    wait_idle();
    // Timeout with ack suppressed, then m1 serviced normally.
    do_reset();
    s_en = 0;
    @(negedge clk);
    set_m(0, 1, 0, DM_DATA0, '0);
    set_m(1, 1, 0, DM_DATA0, '0);
    wait_grant(g);
    chk("timeout owner", g, 2'b01);
    n = 0;
    while (s_cyc && n < 200) begin n++; @(negedge clk); end
    chk("busy cycles before abort", n, TO);
    chk("m0 err raised", m0_err, 1);
    chk("m1 err quiet", m1_err, 0);
    chk("err data zero", m0_rdat, 0);
    repeat (3) @(negedge clk);
    chk("err held", {m0_err, s_cyc}, 2'b10);
    s_en = 1;
    set_m(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("err cleared in gap", {m0_err, busy}, 2'b01);
    wait_grant(g);
    chk("m1 after timeout", g, 2'b10);
    wait_ack(1);
    set_m(1, 0, 0, '0, '0);
    wait_idle();
    // Abandon before ack.
    s_wait = 10;
    @(negedge clk);
    set_m(0, 1, 0, DM_DATA0, '0);
    wait_grant(g);
    repeat (2) @(negedge clk);
    set_m(0, 0, 0, '0, '0);
    @(negedge clk);
    chk("abandon no err", m0_err, 0);
    chk("abandon gap", {busy, s_cyc, grant}, 4'b1000);
    wait_idle();
    // Reset in the middle of a transaction restores last_grant.
    @(negedge clk);
    set_m(0, 1, 0, DM_DATA0, '0);
    wait_grant(g);
    chk("pre-reset owner", g, 2'b01);
    rst = 1;
    @(negedge clk);
    chk("reset aborts slave", {s_cyc, s_stb}, 0);
    chk("reset aborts grant", {grant, busy}, 0);
    chk("reset no err", {m0_err, m0_ack}, 0);
    rst = 0;
    s_wait = 0;
    set_m(0, 0, 0, '0, '0);
    @(negedge clk);
    set_m(0, 1, 0, DM_DATA0, '0);
    set_m(1, 1, 0, DM_DATA0, '0);
    wait_grant(g);
    chk("last_grant restored", g, 2'b01);
    wait_ack(0);
    set_m(0, 0, 0, '0, '0);
    set_m(1, 0, 0, '0, '0);
    wait_idle();
`ifdef DM_ARB_STATS_EN
    do_reset();
    xfer(0, 0, DM_DATA0, '0, rd);
    xfer(1, 0, DM_DATA0, '0, rd);
    xfer(0, 0, DM_DATA0, '0, rd);
    xfer(1, 0, DM_DATA0, '0, rd);
    s_en = 0;
    @(negedge clk);
    set_m(0, 1, 0, DM_DATA0, '0);
    n = 0;
    while (!m0_err && n < 200) begin @(negedge clk); n++; end
    s_en = 1;
    set_m(0, 0, 0, '0, '0);
    wait_idle();
    chk("m0 grant count", m0_gc, 3);
    chk("m1 grant count", m1_gc, 2);
    chk("timeout count", to_c, 1);
`endif
    // Randomized traffic against the transaction-level model.
    do_reset();
    s_rand = 1;
    mon = 1;
    fork
      run_master(0);
      run_master(1);
      grant_order();
    join
    mon = 0;
    s_rand = 0;
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
